// File: rtl/cnn_stage_scheduler_if.sv
// ---------------------------------------------------------------------------
// cnn_stage_scheduler_if
// Signal bundle between the frame scheduler and the CNN pipeline stages
// (conv2d -> relu -> maxpool -> flatten -> dense -> UART TX).
//
// Handshake: there is no valid/ready pair on this bundle. Every *_start,
// *_done, frame_loaded, frame_done and err_clear is a one-cycle pulse that
// is acted on at the rising clock edge where it is sampled high; the sender
// never waits for an acknowledge. tx_busy and abort are levels, sampled
// every edge. own is a registered one-hot grant (at most one bit set) that
// the top-level muxes use to steer the CONV/POOL BRAM ports.
//
// Modports
//   master : the scheduler (drives starts, grant, status; reads dones)
//   slave  : the pipeline / top level (drives dones, reads starts, grant)
// ---------------------------------------------------------------------------
interface cnn_stage_scheduler_if #(
   parameter int CYC_W = 32
) ();
   // pipeline -> scheduler
   logic             frame_loaded;
   logic             conv_done;
   logic             relu_done;
   logic             pool_done;
   logic             dense_done;
   logic             tx_busy;
   logic             abort;
   logic             err_clear;
   // scheduler -> pipeline
   logic             conv_start;
   logic             relu_start;
   logic             pool_start;
   logic             dense_start;
   logic             tx_start;
   logic [3:0]       own;
   logic             busy;
   logic             frame_done;
   logic             overrun;
   logic             timeout_err;
   logic [2:0]       err_stage;
   logic [CYC_W-1:0] last_frame_cycles;

   modport master (
      input  frame_loaded, conv_done, relu_done, pool_done, dense_done,
             tx_busy, abort, err_clear,
      output conv_start, relu_start, pool_start, dense_start, tx_start,
             own, busy, frame_done, overrun, timeout_err, err_stage,
             last_frame_cycles
   );

   modport slave (
      output frame_loaded, conv_done, relu_done, pool_done, dense_done,
             tx_busy, abort, err_clear,
      input  conv_start, relu_start, pool_start, dense_start, tx_start,
             own, busy, frame_done, overrun, timeout_err, err_stage,
             last_frame_cycles
   );
endinterface

// File: rtl/cnn_stage_scheduler.sv
// ---------------------------------------------------------------------------
// cnn_stage_scheduler
// Frame-level sequencer and BRAM-port owner for the CNN pipeline. Walks one
// frame through conv -> relu -> pool -> flatten -> dense -> TX, issuing a
// one-cycle start pulse per stage together with a registered one-hot grant.
// Adds a per-stage watchdog, abort, frame overrun detection and a
// frame latency measurement.
//
// Parameters
//   TIMEOUT_CYCLES : cycles a watched stage may run before its exit
//                    condition; 0 disables the watchdog
//   CYC_W          : width of the latency counter / last_frame_cycles
// Ports
//   clk          : system clock
//   reset_n      : asynchronous active-low reset (synchronously released
//                  upstream)
//   bus          : cnn_stage_scheduler_if.master (pulses, grant, status)
//   o_dbg_state  : current FSM state encoding, for checkers / debug
//
// Grant encoding: own[0] conv, own[1] relu, own[2] pool, own[3] dense.
// err_stage codes: 0 conv, 1 relu, 2 pool, 3 dense, 4 tx.
// All outputs are registered; every output register is written in the
// single FSM process below.
// ---------------------------------------------------------------------------
module cnn_stage_scheduler #(
   parameter int TIMEOUT_CYCLES = 200_000,
   parameter int CYC_W          = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   cnn_stage_scheduler_if.master bus,
   output logic [2:0]            o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CONV  = 3'd1,
      S_RELU  = 3'd2,
      S_POOL  = 3'd3,
      S_FLAT  = 3'd4,
      S_DENSE = 3'd5,
      S_TXW   = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   // Watchdog counter only has to reach TIMEOUT_CYCLES-1.
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST =
      WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

   localparam logic [3:0] OWN_NONE  = 4'b0000;
   localparam logic [3:0] OWN_CONV  = 4'b0001;
   localparam logic [3:0] OWN_RELU  = 4'b0010;
   localparam logic [3:0] OWN_POOL  = 4'b0100;
   localparam logic [3:0] OWN_DENSE = 4'b1000;

   state_t           r_state;
   logic [WD_W-1:0]  r_wd;
   logic [CYC_W-1:0] r_lat;
   logic [CYC_W-1:0] r_last;
   logic             r_conv_start;
   logic             r_relu_start;
   logic             r_pool_start;
   logic             r_dense_start;
   logic             r_tx_start;
   logic             r_frame_done;
   logic [3:0]       r_own;
   logic             r_busy;
   logic             r_overrun;
   logic             r_timeout_err;
   logic [2:0]       r_err_stage;

   logic             w_wd_expire;
   logic [CYC_W-1:0] w_lat_next;
   logic             w_in_frame;

   // The count held in r_wd is the number of completed cycles in the current
   // watched state, so expiry fires on the TIMEOUT_CYCLES-th cycle. The
   // exit condition is tested first in every state, so a done pulse landing
   // in the expiry cycle still wins.
   assign w_wd_expire = (TIMEOUT_CYCLES != 0) && (r_wd == WD_LAST);

   // Saturating increment; also the value copied out on tx_start, so the
   // final TXW cycle is included in the reported latency.
   assign w_lat_next = (r_lat == {CYC_W{1'b1}}) ? r_lat : (r_lat + CYC_W'(1));

   // States in which a new frame_loaded counts as an overrun. ERR is
   // excluded on purpose: a faulted pipeline silently drops frames.
   assign w_in_frame = (r_state != S_IDLE) && (r_state != S_ERR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_wd          <= '0;
         r_lat         <= '0;
         r_last        <= '0;
         r_conv_start  <= 1'b0;
         r_relu_start  <= 1'b0;
         r_pool_start  <= 1'b0;
         r_dense_start <= 1'b0;
         r_tx_start    <= 1'b0;
         r_frame_done  <= 1'b0;
         r_own         <= OWN_NONE;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_err_stage   <= 3'd0;
      end else begin
         // Pulses are one cycle wide unless re-asserted below.
         r_conv_start  <= 1'b0;
         r_relu_start  <= 1'b0;
         r_pool_start  <= 1'b0;
         r_dense_start <= 1'b0;
         r_tx_start    <= 1'b0;
         r_frame_done  <= 1'b0;

         // Free-running; cleared on entry to every watched state.
         r_wd <= r_wd + WD_ONE;

         if (r_busy) begin
            r_lat <= w_lat_next;
         end

         // A new error event in the same cycle as err_clear is kept
         // (assignments further down override these clears).
         if (bus.err_clear) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
         end

         // Covers the TXW -> IDLE edge too: state is still TXW there.
         if (bus.frame_loaded && w_in_frame) begin
            r_overrun <= 1'b1;
         end

         if (bus.abort) begin
            // abort beats every transition, including a coincident done.
            r_state <= S_IDLE;
            r_own   <= OWN_NONE;
            r_busy  <= 1'b0;
            r_lat   <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (bus.frame_loaded) begin
                     r_state      <= S_CONV;
                     r_conv_start <= 1'b1;
                     r_own        <= OWN_CONV;
                     r_busy       <= 1'b1;
                     r_wd         <= '0;
                     r_lat        <= '0;
                  end
               end

               S_CONV: begin
                  if (bus.conv_done) begin
                     r_state      <= S_RELU;
                     r_relu_start <= 1'b1;
                     r_own        <= OWN_RELU;
                     r_wd         <= '0;
                  end else if (w_wd_expire) begin
                     r_state       <= S_ERR;
                     r_own         <= OWN_NONE;
                     r_busy        <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_err_stage   <= 3'd0;
                  end
               end

               S_RELU: begin
                  if (bus.relu_done) begin
                     r_state      <= S_POOL;
                     r_pool_start <= 1'b1;
                     r_own        <= OWN_POOL;
                     r_wd         <= '0;
                  end else if (w_wd_expire) begin
                     r_state       <= S_ERR;
                     r_own         <= OWN_NONE;
                     r_busy        <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_err_stage   <= 3'd1;
                  end
               end

               S_POOL: begin
                  if (bus.pool_done) begin
                     // One dead cycle with no owner while flatten reads out,
                     // so the POOL and dense grants never touch.
                     r_state <= S_FLAT;
                     r_own   <= OWN_NONE;
                  end else if (w_wd_expire) begin
                     r_state       <= S_ERR;
                     r_own         <= OWN_NONE;
                     r_busy        <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_err_stage   <= 3'd2;
                  end
               end

               S_FLAT: begin
                  r_state       <= S_DENSE;
                  r_dense_start <= 1'b1;
                  r_own         <= OWN_DENSE;
                  r_wd          <= '0;
               end

               S_DENSE: begin
                  if (bus.dense_done) begin
                     r_state <= S_TXW;
                     r_own   <= OWN_NONE;
                     r_wd    <= '0;
                  end else if (w_wd_expire) begin
                     r_state       <= S_ERR;
                     r_own         <= OWN_NONE;
                     r_busy        <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_err_stage   <= 3'd3;
                  end
               end

               S_TXW: begin
                  if (!bus.tx_busy) begin
                     r_state      <= S_IDLE;
                     r_tx_start   <= 1'b1;
                     r_frame_done <= 1'b1;
                     r_busy       <= 1'b0;
                     r_last       <= w_lat_next;
                  end else if (w_wd_expire) begin
                     r_state       <= S_ERR;
                     r_own         <= OWN_NONE;
                     r_busy        <= 1'b0;
                     r_timeout_err <= 1'b1;
                     r_err_stage   <= 3'd4;
                  end
               end

               S_ERR: begin
                  // frame_loaded is deliberately not looked at here.
                  if (bus.err_clear) begin
                     r_state <= S_IDLE;
                  end
               end

               default: begin
                  r_state <= S_IDLE;
                  r_own   <= OWN_NONE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.conv_start        = r_conv_start;
   assign bus.relu_start        = r_relu_start;
   assign bus.pool_start        = r_pool_start;
   assign bus.dense_start       = r_dense_start;
   assign bus.tx_start          = r_tx_start;
   assign bus.frame_done        = r_frame_done;
   assign bus.own               = r_own;
   assign bus.busy              = r_busy;
   assign bus.overrun           = r_overrun;
   assign bus.timeout_err       = r_timeout_err;
   assign bus.err_stage         = r_err_stage;
   assign bus.last_frame_cycles = r_last;
   assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_cnn_stage_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cnn_stage_scheduler
// A frame-level plan is built from the scheduler's timing rules: every input
// pulse goes into a per-edge stimulus table, and every observable output
// event (start pulses, grant/busy/flag changes) goes into exp_q with the
// edge number it must appear on. The driver replays the table; the monitor
// pops exp_q whenever the DUT shows an event and compares.
// Edge k = k-th rising clock edge; inputs for edge k are driven just after
// the falling edge before it, outputs of edge k are sampled on the falling
// edge after it.
// ---------------------------------------------------------------------------
module tb_cnn_stage_scheduler;

   localparam int TMO   = 16;
   localparam int CYC_W = 32;
   localparam int W     = 48;   // {edge[31:0], observed fields[15:0]}

   // stimulus bit positions
   localparam int B_FL = 0;
   localparam int B_CD = 1;     // conv/relu/pool/dense done = B_CD + stage
   localparam int B_TB = 5;
   localparam int B_AB = 6;
   localparam int B_EC = 7;
   localparam int B_RS = 8;

   // start pulse vectors {conv, relu, pool, dense, tx}
   localparam logic [4:0] ST_NONE  = 5'b00000;
   localparam logic [4:0] ST_CONV  = 5'b10000;
   localparam logic [4:0] ST_RELU  = 5'b01000;
   localparam logic [4:0] ST_POOL  = 5'b00100;
   localparam logic [4:0] ST_DENSE = 5'b00010;
   localparam logic [4:0] ST_TX    = 5'b00001;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] dbg_state;
   int         cyc = 0;

   cnn_stage_scheduler_if #(.CYC_W(CYC_W)) bus ();

   cnn_stage_scheduler #(
      .TIMEOUT_CYCLES (TMO),
      .CYC_W          (CYC_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   logic [8:0]   stim[int];
   int           lfc_zero_cyc = -1;
   int           end_cyc = 0;
   int           n_checks = 0;
   int           n_err = 0;
   bit           mon_en = 1'b0;

   // reference flags
   bit           m_ovr = 1'b0;
   bit           m_tmo = 1'b0;
   logic [2:0]   m_es = 3'd0;
   bit           m_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void add(input int k, input int b);
      logic [8:0] v;
      v = stim.exists(k) ? stim[k] : 9'd0;
      v[b] = 1'b1;
      stim[k] = v;
   endfunction

   function automatic void push(input int k, input logic [4:0] st, input logic fd,
                                input logic [3:0] own, input logic busy);
      exp_q.push_back({32'(k), st, fd, own, busy, m_ovr, m_tmo, m_es});
   endfunction

   // One frame accepted at edge n. d*: edges from a stage's start to its done
   // (beyond TMO means the done never comes). w: edges from TXW entry to
   // tx_busy low. ovr_mode: 1 = frame_loaded one edge into dense,
   // 2 = frame_loaded on the TX exit edge. strays: inactive-stage done
   // pulses one edge into each stage.
   function automatic int plan_frame(input int n, input int dc, input int dr, input int dp,
                                     input int dd, input int w, input int ovr_mode,
                                     input bit strays);
      int d[4];
      int e;
      d[0] = dc; d[1] = dr; d[2] = dp; d[3] = dd;
      m_err = 1'b0;
      add(n, B_FL);
      push(n, ST_CONV, 1'b0, 4'b0001, 1'b1);
      e = n;
      for (int s = 0; s < 4; s++) begin
         if (strays && d[s] >= 2) add(e + 1, B_CD + ((s + 3) % 4));
         if (s == 3 && ovr_mode == 1 && d[s] >= 2) begin
            add(e + 1, B_FL);
            if (!m_ovr) begin
               m_ovr = 1'b1;
               push(e + 1, ST_NONE, 1'b0, 4'b1000, 1'b1);
            end
         end
         if (d[s] > TMO) begin
            m_tmo = 1'b1;
            m_es  = 3'(s);
            m_err = 1'b1;
            push(e + TMO, ST_NONE, 1'b0, 4'b0000, 1'b0);
            return e + TMO;
         end
         add(e + d[s], B_CD + s);
         e = e + d[s];
         case (s)
            0: push(e, ST_RELU, 1'b0, 4'b0010, 1'b1);
            1: push(e, ST_POOL, 1'b0, 4'b0100, 1'b1);
            2: begin
               push(e, ST_NONE, 1'b0, 4'b0000, 1'b1);
               e = e + 1;
               push(e, ST_DENSE, 1'b0, 4'b1000, 1'b1);
            end
            default: push(e, ST_NONE, 1'b0, 4'b0000, 1'b1);
         endcase
      end
      if (w > TMO) begin
         for (int k = e; k <= e + TMO; k++) add(k, B_TB);
         m_tmo = 1'b1;
         m_es  = 3'd4;
         m_err = 1'b1;
         push(e + TMO, ST_NONE, 1'b0, 4'b0000, 1'b0);
         return e + TMO;
      end
      for (int k = e; k < e + w; k++) add(k, B_TB);
      if (ovr_mode == 2) begin
         add(e + w, B_FL);
         m_ovr = 1'b1;
      end
      push(e + w, ST_TX, 1'b1, 4'b0000, 1'b0);
      lat_q.push_back(e + w - n);
      return e + w;
   endfunction

   function automatic void plan_clear(input int k);
      add(k, B_EC);
      m_err = 1'b0;
      if (m_ovr || m_tmo) begin
         m_ovr = 1'b0;
         m_tmo = 1'b0;
         push(k, ST_NONE, 1'b0, 4'b0000, 1'b0);
      end
   endfunction

   // Abort a edges into POOL, together with pool_done.
   function automatic int plan_abort(input int n, input int dc, input int dr, input int a);
      int p;
      add(n, B_FL);
      push(n, ST_CONV, 1'b0, 4'b0001, 1'b1);
      add(n + dc, B_CD);
      push(n + dc, ST_RELU, 1'b0, 4'b0010, 1'b1);
      p = n + dc + dr;
      add(p, B_CD + 1);
      push(p, ST_POOL, 1'b0, 4'b0100, 1'b1);
      add(p + a, B_AB);
      add(p + a, B_CD + 2);
      push(p + a, ST_NONE, 1'b0, 4'b0000, 1'b0);
      return p + a;
   endfunction

   // reset_n low for edge n+r, r edges into CONV.
   function automatic int plan_reset(input int n, input int r);
      add(n, B_FL);
      push(n, ST_CONV, 1'b0, 4'b0001, 1'b1);
      add(n + r, B_RS);
      m_ovr = 1'b0;
      m_tmo = 1'b0;
      m_es  = 3'd0;
      push(n + r, ST_NONE, 1'b0, 4'b0000, 1'b0);
      lfc_zero_cyc = n + r;
      return n + r;
   endfunction

   function automatic int rnd_dly();
      return ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(1, 10));
   endfunction

   function automatic void build_plan();
      int t;
      int e;
      int om;
      t = 6;
      // nominal: every done 5 edges after its start, tx idle
      t = plan_frame(t, 5, 5, 5, 5, 1, 0, 1'b0) + 3;
      // tx_busy high for 10 cycles after dense_done
      t = plan_frame(t, 5, 5, 5, 5, 11, 0, 1'b0) + 3;
      // relu_done never arrives; frame_loaded in ERR is ignored
      e = plan_frame(t, 5, 99, 5, 5, 1, 0, 1'b0);
      add(e + 3, B_FL);
      add(e + 4, B_CD);
      plan_clear(e + 6);
      t = e + 9;
      // abort two cycles into POOL with pool_done, then a normal frame
      t = plan_abort(t, 5, 5, 2) + 3;
      t = plan_frame(t, 3, 4, 2, 3, 2, 0, 1'b0) + 3;
      // overrun during DENSE plus stray dones, then clear
      t = plan_frame(t, 4, 4, 4, 6, 2, 1, 1'b1);
      plan_clear(t + 2);
      t = t + 5;
      // reset mid-CONV
      t = plan_reset(t, 2) + 3;
      // done exactly on the expiry cycle, tx exit on the expiry cycle,
      // frame_loaded on the TXW -> IDLE edge
      t = plan_frame(t, 16, 1, 1, 1, 16, 2, 1'b0);
      plan_clear(t + 2);
      t = t + 5;
      // randomized frames
      for (int i = 0; i < 12; i++) begin
         om = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         e = plan_frame(t, rnd_dly(), rnd_dly(), rnd_dly(), rnd_dly() + ((om == 1) ? 1 : 0),
                        ($urandom_range(0, 7) == 0) ? 17 : int'($urandom_range(1, 8)),
                        om, 1'($urandom_range(0, 1)));
         if (m_err) begin
            if ($urandom_range(0, 1) == 0) plan_clear(e + 2);
            else add(e + 2, B_AB);
            m_err = 1'b0;
            e = e + 2;
         end else if (m_ovr && $urandom_range(0, 1) == 0) begin
            plan_clear(e + 2);
            e = e + 2;
         end
         t = e + int'($urandom_range(2, 5));
      end
      end_cyc = t + 5;
   endfunction

   // ---------------- driver ----------------
   task automatic apply(input int k);
      logic [8:0] v;
      v = stim.exists(k) ? stim[k] : 9'd0;
      bus.frame_loaded = v[B_FL];
      bus.conv_done    = v[B_CD];
      bus.relu_done    = v[B_CD + 1];
      bus.pool_done    = v[B_CD + 2];
      bus.dense_done   = v[B_CD + 3];
      bus.tx_busy      = v[B_TB];
      bus.abort        = v[B_AB];
      bus.err_clear    = v[B_EC];
      reset_n          = !v[B_RS];
   endtask

   function automatic logic [15:0] sample_obs();
      return {bus.conv_start, bus.relu_start, bus.pool_start, bus.dense_start,
              bus.tx_start, bus.frame_done, bus.own, bus.busy, bus.overrun,
              bus.timeout_err, bus.err_stage};
   endfunction

   initial begin
      reset_n = 1'b0;
      apply(0);
      reset_n = 1'b0;
      build_plan();
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(sample_obs()), 64'd0);
      check("reset_last_frame_cycles", 64'(bus.last_frame_cycles), 64'd0);
      #1;
      mon_en = 1'b1;
      apply(cyc + 1);
      while (cyc < end_cyc) begin
         @(negedge clk);
         #1;
         apply(cyc + 1);
      end
      repeat (2) @(negedge clk);
      check("events_left", 64'(exp_q.size()), 64'd0);
      check("latencies_left", 64'(lat_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // ---------------- monitor ----------------
   logic [9:0] prev_lvl = 10'd0;   // own, busy, overrun, timeout_err, err_stage

   always @(negedge clk) begin
      logic [15:0]  obs;
      logic [W-1:0] exp_v;
      if (mon_en) begin
         obs = sample_obs();
         check("own_onehot", 64'($onehot0(bus.own)), 64'd1);
         if (obs[15:10] != 6'd0 || obs[9:0] != prev_lvl) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL event: got unexpected edge=%0d fields=%h, nothing expected", cyc, obs);
            end else begin
               exp_v = exp_q.pop_front();
               check("event", 64'({32'(cyc), obs}), 64'(exp_v));
            end
         end
         if (bus.frame_done) begin
            if (lat_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL last_frame_cycles: got frame_done at edge %0d, none expected", cyc);
            end else begin
               check("last_frame_cycles", 64'(bus.last_frame_cycles), 64'(lat_q.pop_front()));
            end
         end
         if (cyc == lfc_zero_cyc) begin
            check("reset_mid_frame_lfc", 64'(bus.last_frame_cycles), 64'd0);
         end
         prev_lvl = obs[9:0];
      end
   end

endmodule
